path_delay_checker: RTL and testbench

//   Clocked checker that sits directly downstream of a path-delay DUT (a,b -> x).

---
 rtl/path_delay_checker.sv | 176 +++++++++++++++++
 tb/tb_path_delay_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/path_delay_checker.sv
// rtl/path_delay_checker.sv - measures a->x / b->x propagation in cycles against a delay window
module path_delay_checker #(
    parameter int CW      = 8,
    parameter int MIN_DLY = 10,
    parameter int MAX_DLY = 21,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          in_a,
    input  logic          in_b,
    input  logic          out_x,
    output logic          meas_valid,
    output logic [CW-1:0] meas_cycles,
    output logic [1:0]    meas_src,
    output logic          early_err,
    output logic          late_err,
    output logic          timeout_err,
    output logic          spur_err,
    output logic          retrig,
    output logic          err_sticky
);

    localparam logic [CW-1:0] MIN_C     = CW'(MIN_DLY);
    localparam logic [CW-1:0] MAX_C     = CW'(MAX_DLY);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    src_q, src_d;

    logic          prev_a_q, prev_b_q, prev_x_q;

    logic          meas_valid_q, meas_valid_d;
    logic [CW-1:0] meas_cycles_q, meas_cycles_d;
    logic [1:0]    meas_src_q, meas_src_d;
    logic          early_q, early_d;
    logic          late_q, late_d;
    logic          timeout_q, timeout_d;
    logic          spur_q, spur_d;
    logic          retrig_q, retrig_d;
    logic          sticky_q, sticky_d;

    logic          da, db, dx, in_chg;

    // Edge-to-edge change flags against last cycle's samples.
    assign da     = in_a ^ prev_a_q;
    assign db     = in_b ^ prev_b_q;
    assign dx     = out_x ^ prev_x_q;
    assign in_chg = da | db;

    // Previous-value samples run in every state; reset loads the live inputs
    // so releasing reset never looks like a transition.
    always_ff @(posedge clk) begin
        prev_a_q <= in_a;
        prev_b_q <= in_b;
        prev_x_q <= out_x;
    end

    // Next-state and registered-result decode; a new input change in WAIT
    // wins over a same-edge x change, and enable low aborts silently.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        src_d         = src_q;
        meas_valid_d  = 1'b0;
        meas_cycles_d = meas_cycles_q;
        meas_src_d    = meas_src_q;
        early_d       = 1'b0;
        late_d        = 1'b0;
        timeout_d     = 1'b0;
        spur_d        = 1'b0;
        retrig_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && in_chg) begin
                    state_d = ST_WAIT;
                    cnt_d   = ONE_C;
                    src_d   = {db, da};
                end else if (dx && !in_chg) begin
                    spur_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (in_chg) begin
                    cnt_d    = ONE_C;
                    src_d    = {db, da};
                    retrig_d = 1'b1;
                end else if (dx) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    meas_valid_d  = 1'b1;
                    meas_cycles_d = cnt_q;
                    meas_src_d    = src_q;
                    early_d       = (cnt_q < MIN_C);
                    late_d        = (cnt_q > MAX_C);
                end else if (cnt_q >= TIMEOUT_C) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    meas_valid_d  = 1'b1;
                    meas_cycles_d = TIMEOUT_C;
                    meas_src_d    = src_q;
                    timeout_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        sticky_d = sticky_q | early_d | late_d | timeout_d | spur_d;
    end

    // State, counter and source capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    // Result and error registers; pulses last exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meas_valid_q  <= 1'b0;
            meas_cycles_q <= '0;
            meas_src_q    <= 2'b00;
            early_q       <= 1'b0;
            late_q        <= 1'b0;
            timeout_q     <= 1'b0;
            spur_q        <= 1'b0;
            retrig_q      <= 1'b0;
            sticky_q      <= 1'b0;
        end else begin
            meas_valid_q  <= meas_valid_d;
            meas_cycles_q <= meas_cycles_d;
            meas_src_q    <= meas_src_d;
            early_q       <= early_d;
            late_q        <= late_d;
            timeout_q     <= timeout_d;
            spur_q        <= spur_d;
            retrig_q      <= retrig_d;
            sticky_q      <= sticky_d;
        end
    end

    assign meas_valid  = meas_valid_q;
    assign meas_cycles = meas_cycles_q;
    assign meas_src    = meas_src_q;
    assign early_err   = early_q;
    assign late_err    = late_q;
    assign timeout_err = timeout_q;
    assign spur_err    = spur_q;
    assign retrig      = retrig_q;
    assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_path_delay_checker.sv
// tb/tb_path_delay_checker.sv - directed vector bench for path_delay_checker
module tb_path_delay_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       in_a = 1'b1;
    logic       in_b = 1'b1;
    logic       out_x = 1'b0;
    logic       meas_valid;
    logic [7:0] meas_cycles;
    logic [1:0] meas_src;
    logic       early_err, late_err, timeout_err, spur_err, retrig, err_sticky;

    int checks = 0;
    int errors = 0;

    path_delay_checker #(
        .CW(8), .MIN_DLY(10), .MAX_DLY(21), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_a(in_a), .in_b(in_b), .out_x(out_x),
        .meas_valid(meas_valid), .meas_cycles(meas_cycles), .meas_src(meas_src),
        .early_err(early_err), .late_err(late_err), .timeout_err(timeout_err),
        .spur_err(spur_err), .retrig(retrig), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tog_a;
        logic       tog_b;
        int         x_dly;      // 0 = x never toggles
        int         exp_k;      // negedge index (after the input toggle) of the pulse
        logic [7:0] exp_cycles;
        logic [1:0] exp_src;
        logic       exp_early;
        logic       exp_late;
        logic       exp_to;
        logic       exp_sticky;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         k_seen = 0;
        int         rt = 0;
        logic [7:0] cyc = '0;
        logic [1:0] src = '0;
        logic       e = 1'b0, l = 1'b0, t = 1'b0, s = 1'b0;
        @(negedge clk);
        if (v.tog_a) in_a = ~in_a;
        if (v.tog_b) in_b = ~in_b;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (retrig) rt++;
            if (meas_valid) begin
                k_seen = k; cyc = meas_cycles; src = meas_src;
                e = early_err; l = late_err; t = timeout_err; s = err_sticky;
                break;
            end
            if (k == v.x_dly) out_x = ~out_x;
        end
        check($sformatf("v%0d latency", idx), k_seen, v.exp_k);
        check($sformatf("v%0d meas_cycles", idx), cyc, v.exp_cycles);
        check($sformatf("v%0d meas_src", idx), src, v.exp_src);
        check($sformatf("v%0d early_err", idx), e, v.exp_early);
        check($sformatf("v%0d late_err", idx), l, v.exp_late);
        check($sformatf("v%0d timeout_err", idx), t, v.exp_to);
        check($sformatf("v%0d err_sticky", idx), s, v.exp_sticky);
        check($sformatf("v%0d no retrig", idx), rt, 0);
        @(negedge clk);
        check($sformatf("v%0d pulse width", idx),
              {meas_valid, early_err, late_err, timeout_err}, 0);
        check($sformatf("v%0d cycles held", idx), meas_cycles, v.exp_cycles);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int rk;
        int vk;
        logic [7:0] cyc;
        logic [1:0] src;

        //                tog_a tog_b dly  k    cyc    src    E L T S
        vecs[0] = '{1'b1, 1'b0, 10,  11,  8'd10,  2'b01, 0, 0, 0, 0};
        vecs[1] = '{1'b0, 1'b1, 21,  22,  8'd21,  2'b10, 0, 0, 0, 0};
        vecs[2] = '{1'b1, 1'b0, 1,   2,   8'd1,   2'b01, 1, 0, 0, 1};
        vecs[3] = '{1'b0, 1'b1, 9,   10,  8'd9,   2'b10, 1, 0, 0, 1};
        vecs[4] = '{1'b1, 1'b0, 22,  23,  8'd22,  2'b01, 0, 1, 0, 1};
        vecs[5] = '{1'b0, 1'b1, 25,  26,  8'd25,  2'b10, 0, 1, 0, 1};
        vecs[6] = '{1'b1, 1'b0, 5,   6,   8'd5,   2'b01, 1, 0, 0, 1};
        vecs[7] = '{1'b1, 1'b1, 0,   256, 8'd255, 2'b11, 0, 0, 1, 1};

        // Reset with a=b=1, x=0 held, then a quiet period.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset outputs", {meas_valid, meas_cycles, meas_src, early_err, late_err,
                                timeout_err, spur_err, retrig, err_sticky}, 0);
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (meas_valid || spur_err || retrig) seen++;
        end
        check("quiet after reset", seen, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Retrigger: a, then b 4 cycles later, then x 12 cycles after b.
        rk = 0; vk = 0; cyc = '0; src = '0;
        @(negedge clk);
        in_a = ~in_a;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (retrig && rk == 0) rk = k;
            if (meas_valid) begin
                vk = k; cyc = meas_cycles; src = meas_src;
                break;
            end
            if (k == 4)  in_b = ~in_b;
            if (k == 16) out_x = ~out_x;
        end
        check("retrig position", rk, 5);
        check("retrig latency", vk, 17);
        check("retrig meas_cycles", cyc, 12);
        check("retrig meas_src", src, 2'b10);
        repeat (2) @(negedge clk);

        // Spurious x change while idle.
        out_x = ~out_x;
        @(negedge clk);
        check("spur pulse", {spur_err, meas_valid}, 2'b10);
        @(negedge clk);
        check("spur width", spur_err, 0);
        check("sticky after spur", err_sticky, 1);

        // Abort by reset at cycle 6, then x toggles.
        in_a = ~in_a;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("sticky cleared by rst", err_sticky, 0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (meas_valid) seen++;
            if (k == 4) out_x = ~out_x;
        end
        check("no result after rst abort", seen, 0);

        // Abort by enable low at cycle 6, then x toggles.
        in_b = ~in_b;
        repeat (6) @(negedge clk);
        enable = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (meas_valid) seen++;
            if (k == 4) out_x = ~out_x;
            if (k == 10) enable = 1'b1;
        end
        check("no result after enable abort", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
